// File: rtl/sequence_checker_pkg.sv
// Shared definitions for the test-pattern path: pattern length, the
// alignment byte, the pattern itself and the checker state encoding.
// The upstream generator imports this same package so both ends agree.
package seq_pkg;

  localparam int SEQ_LEN = 8;

  // Unique alignment byte; appears only at pattern index 0
  localparam logic [7:0] SEQ_START = 8'hAF;

  // Pattern entry [i] is the byte expected at index i (entry [0] is AF)
  localparam logic [SEQ_LEN-1:0][7:0] SEQ_PATTERN = {
    8'h8D, 8'h0B, 8'hE2, 8'hFF, 8'h78, 8'hE2, 8'hBC, 8'hAF
  };

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  // Expected byte for a given pattern index
  function automatic logic [7:0] pattern_at(input logic [2:0] idx);
    return SEQ_PATTERN[idx];
  endfunction

endpackage

// File: rtl/sequence_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Count up on inc, stick at all-ones, clear takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/sequence_checker.sv
// Link-integrity monitor for the 8-byte test pattern. Hunts for the unique
// start byte, confirms alignment over a run of matches, then checks every
// byte and reports mismatches, lock loss and a saturating error count.
module sequence_checker
  import seq_pkg::*;
#(
  parameter int LOCK_CONFIRM = 8,
  parameter int LOSS_THRESH  = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clear_counts,
  output logic             locked,
  output logic [2:0]       exp_idx,
  output logic             mismatch,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count
);

  // Run values at which the next event completes lock / drops lock
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CONFIRM - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_THRESH - 1);

  state_t     state;
  logic [7:0] match_run;
  logic [3:0] miss_run;
  logic       is_match;
  logic       count_inc;

  assign is_match  = (in_data == pattern_at(exp_idx));
  assign count_inc = in_valid && (state == LOCKED) && !is_match;

  // Alignment FSM with registered status outputs and one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      locked    <= 1'b0;
      exp_idx   <= 3'd0;
      mismatch  <= 1'b0;
      lock_lost <= 1'b0;
      match_run <= 8'd0;
      miss_run  <= 4'd0;
    end else begin
      mismatch  <= 1'b0;
      lock_lost <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            if (in_data == SEQ_START) begin
              state     <= VERIFY;
              exp_idx   <= 3'd1;
              match_run <= 8'd1;
            end else begin
              exp_idx <= 3'd0;
            end
          end
          VERIFY: begin
            if (is_match) begin
              exp_idx   <= exp_idx + 3'd1;
              match_run <= match_run + 8'd1;
              if (match_run == LOCK_LAST) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_run <= 4'd0;
              end
            end else if (in_data == SEQ_START) begin
              exp_idx   <= 3'd1;
              match_run <= 8'd1;
            end else begin
              state     <= HUNT;
              exp_idx   <= 3'd0;
              match_run <= 8'd0;
            end
          end
          LOCKED: begin
            if (is_match) begin
              exp_idx  <= exp_idx + 3'd1;
              miss_run <= 4'd0;
            end else begin
              mismatch <= 1'b1;
              if (miss_run == LOSS_LAST) begin
                state     <= HUNT;
                locked    <= 1'b0;
                lock_lost <= 1'b1;
                exp_idx   <= 3'd0;
                miss_run  <= 4'd0;
                match_run <= 8'd0;
              end else begin
                exp_idx  <= exp_idx + 3'd1;
                miss_run <= miss_run + 4'd1;
              end
            end
          end
          default: begin
            state   <= HUNT;
            locked  <= 1'b0;
            exp_idx <= 3'd0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_err_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (count_inc),
    .clr  (clear_counts),
    .count(err_count)
  );

endmodule

// File: tb/tb_sequence_checker.sv
// Table-driven bench for sequence_checker. A default instance covers
// alignment, corruption and lock loss; a second instance with a 4-bit
// counter and a loss threshold of 15 exercises counter saturation.
module tb_sequence_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        clear_counts = 1'b0;

  logic        locked, mismatch, lock_lost;
  logic [2:0]  exp_idx;
  logic [15:0] err_count;

  logic        sat_locked, sat_mismatch, sat_lock_lost;
  logic [2:0]  sat_exp_idx;
  logic [3:0]  sat_err_count;

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        clr;
    logic        locked;
    logic [2:0]  idx;
    logic        mis;
    logic        lost;
    logic [15:0] err;
  } vec_t;

  typedef struct {
    logic        sat;
    int          id;
    logic        locked;
    logic [2:0]  idx;
    logic        mis;
    logic        lost;
    logic [15:0] err;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  int         checks = 0;
  int         passes = 0;
  int         vec_id = 0;
  logic [7:0] pat [0:7];

  always #5 clk = ~clk;

  sequence_checker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .clear_counts(clear_counts),
    .locked      (locked),
    .exp_idx     (exp_idx),
    .mismatch    (mismatch),
    .lock_lost   (lock_lost),
    .err_count   (err_count)
  );

  sequence_checker #(
    .LOCK_CONFIRM(8),
    .LOSS_THRESH (15),
    .CNT_W       (4)
  ) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .clear_counts(clear_counts),
    .locked      (sat_locked),
    .exp_idx     (sat_exp_idx),
    .mismatch    (sat_mismatch),
    .lock_lost   (sat_lock_lost),
    .err_count   (sat_err_count)
  );

  // Single comparison: counts every call, prints a line on disagreement
  function automatic void checkField(input string name, input int id,
                                     input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s #%0d: got %0h, expected %0h", name, id, act, req);
  endfunction

  function automatic void addVec(input logic v, input logic [7:0] d, input logic c,
                                 input logic l, input logic [2:0] i, input logic m,
                                 input logic ll, input logic [15:0] e);
    vec_t x;
    x.valid = v; x.data = d; x.clr = c;
    x.locked = l; x.idx = i; x.mis = m; x.lost = ll; x.err = e;
    vecs.push_back(x);
  endfunction

  // Pop the oldest expectation and compare it with the selected instance
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    if (e.sat) begin
      checkField("sat_locked",   e.id, {15'd0, sat_locked},    {15'd0, e.locked});
      checkField("sat_exp_idx",  e.id, {13'd0, sat_exp_idx},   {13'd0, e.idx});
      checkField("sat_mismatch", e.id, {15'd0, sat_mismatch},  {15'd0, e.mis});
      checkField("sat_lost",     e.id, {15'd0, sat_lock_lost}, {15'd0, e.lost});
      checkField("sat_err",      e.id, {12'd0, sat_err_count}, e.err);
    end else begin
      checkField("locked",    e.id, {15'd0, locked},    {15'd0, e.locked});
      checkField("exp_idx",   e.id, {13'd0, exp_idx},   {13'd0, e.idx});
      checkField("mismatch",  e.id, {15'd0, mismatch},  {15'd0, e.mis});
      checkField("lock_lost", e.id, {15'd0, lock_lost}, {15'd0, e.lost});
      checkField("err_count", e.id, err_count,          e.err);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, check after the edge
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic c,
                               input exp_t e);
    @(negedge clk);
    in_valid     = v;
    in_data      = d;
    clear_counts = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runVecs();
    exp_t e;
    foreach (vecs[k]) begin
      vec_id++;
      e.sat = 1'b0; e.id = vec_id;
      e.locked = vecs[k].locked; e.idx = vecs[k].idx;
      e.mis = vecs[k].mis; e.lost = vecs[k].lost; e.err = vecs[k].err;
      applyStimulus(vecs[k].valid, vecs[k].data, vecs[k].clr, e);
    end
    vecs.delete();
  endtask

  task automatic satStep(input logic [7:0] d, input logic c, input logic l,
                         input logic [2:0] i, input logic m, input logic [15:0] er);
    exp_t e;
    vec_id++;
    e.sat = 1'b1; e.id = vec_id;
    e.locked = l; e.idx = i; e.mis = m; e.lost = 1'b0; e.err = er;
    applyStimulus(1'b1, d, c, e);
  endtask

  task automatic checkAllZero(input string tag);
    checkField({tag, "_locked"},    0, {15'd0, locked},    16'd0);
    checkField({tag, "_exp_idx"},   0, {13'd0, exp_idx},   16'd0);
    checkField({tag, "_mismatch"},  0, {15'd0, mismatch},  16'd0);
    checkField({tag, "_lock_lost"}, 0, {15'd0, lock_lost}, 16'd0);
    checkField({tag, "_err_count"}, 0, err_count,          16'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; clear_counts = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    checkAllZero("rst");
    rst_n = 1'b1;
  endtask

  // Pattern byte then an ignored cycle carrying the alignment byte
  function automatic void addPair(input logic [7:0] d, input logic l, input logic [2:0] i);
    addVec(1'b1, d,     1'b0, l, i, 1'b0, 1'b0, 16'd0);
    addVec(1'b0, 8'hAF, 1'b0, l, i, 1'b0, 1'b0, 16'd0);
  endfunction

  initial begin
    logic [2:0]  pos;
    logic [15:0] n_err;
    pat = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

    doReset();

    // Clean stream with a doubled start byte, then lock
    addVec(1, 8'hAF, 0, 0, 3'd1, 0, 0, 16'd0);
    addVec(1, 8'hAF, 0, 0, 3'd1, 0, 0, 16'd0);
    addVec(1, 8'hBC, 0, 0, 3'd2, 0, 0, 16'd0);
    addVec(1, 8'hE2, 0, 0, 3'd3, 0, 0, 16'd0);
    addVec(1, 8'h78, 0, 0, 3'd4, 0, 0, 16'd0);
    addVec(1, 8'hFF, 0, 0, 3'd5, 0, 0, 16'd0);
    addVec(1, 8'hE2, 0, 0, 3'd6, 0, 0, 16'd0);
    addVec(1, 8'h0B, 0, 0, 3'd7, 0, 0, 16'd0);
    addVec(1, 8'h8D, 0, 1, 3'd0, 0, 0, 16'd0);
    addVec(1, 8'hAF, 0, 1, 3'd1, 0, 0, 16'd0);
    addVec(1, 8'hBC, 0, 1, 3'd2, 0, 0, 16'd0);
    addVec(1, 8'hE2, 0, 1, 3'd3, 0, 0, 16'd0);
    addVec(1, 8'h78, 0, 1, 3'd4, 0, 0, 16'd0);
    // Single corrupted byte (FF -> 00)
    addVec(1, 8'h00, 0, 1, 3'd5, 1, 0, 16'd1);
    addVec(1, 8'hE2, 0, 1, 3'd6, 0, 0, 16'd1);
    addVec(1, 8'h0B, 0, 1, 3'd7, 0, 0, 16'd1);
    addVec(1, 8'h8D, 0, 1, 3'd0, 0, 0, 16'd1);
    addVec(1, 8'hAF, 0, 1, 3'd1, 0, 0, 16'd1);
    // Clear on an idle cycle, then three corrupted bytes lose lock
    addVec(0, 8'h00, 1, 1, 3'd1, 0, 0, 16'd0);
    addVec(1, 8'h00, 0, 1, 3'd2, 1, 0, 16'd1);
    addVec(1, 8'h00, 0, 1, 3'd3, 1, 0, 16'd2);
    addVec(1, 8'h00, 0, 0, 3'd0, 1, 1, 16'd3);
    addVec(1, 8'hFF, 0, 0, 3'd0, 0, 0, 16'd3);
    // Relock with an idle gap inside the confirmation run
    addVec(1, 8'hAF, 0, 0, 3'd1, 0, 0, 16'd3);
    addVec(1, 8'hBC, 0, 0, 3'd2, 0, 0, 16'd3);
    addVec(0, 8'hAF, 0, 0, 3'd2, 0, 0, 16'd3);
    addVec(1, 8'hE2, 0, 0, 3'd3, 0, 0, 16'd3);
    addVec(1, 8'h78, 0, 0, 3'd4, 0, 0, 16'd3);
    addVec(1, 8'hFF, 0, 0, 3'd5, 0, 0, 16'd3);
    addVec(1, 8'hE2, 0, 0, 3'd6, 0, 0, 16'd3);
    addVec(1, 8'h0B, 0, 0, 3'd7, 0, 0, 16'd3);
    addVec(1, 8'h8D, 0, 1, 3'd0, 0, 0, 16'd3);
    addVec(1, 8'hAF, 0, 1, 3'd1, 0, 0, 16'd3);
    runVecs();

    doReset();

    // Verify aborted by a non-start mismatch, then E2-first stream with
    // in_valid toggling every other cycle
    addVec(1, 8'hAF, 0, 0, 3'd1, 0, 0, 16'd0);
    addVec(1, 8'hBC, 0, 0, 3'd2, 0, 0, 16'd0);
    addVec(1, 8'h55, 0, 0, 3'd0, 0, 0, 16'd0);
    addPair(8'hE2, 0, 3'd0);
    addPair(8'h0B, 0, 3'd0);
    addPair(8'h8D, 0, 3'd0);
    addPair(8'hAF, 0, 3'd1);
    addPair(8'hBC, 0, 3'd2);
    addPair(8'hE2, 0, 3'd3);
    addPair(8'h78, 0, 3'd4);
    addPair(8'hFF, 0, 3'd5);
    addPair(8'hE2, 0, 3'd6);
    addPair(8'h0B, 0, 3'd7);
    addPair(8'h8D, 1, 3'd0);
    addVec(1, 8'hAF, 0, 1, 3'd1, 0, 0, 16'd0);
    addVec(1, 8'h00, 0, 1, 3'd2, 1, 0, 16'd1);
    runVecs();

    // Asynchronous reset while locked with a mismatch pulse showing
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    addVec(1, 8'hBC, 0, 0, 3'd0, 0, 0, 16'd0);
    addVec(1, 8'hAF, 0, 0, 3'd1, 0, 0, 16'd0);
    runVecs();

    // Saturation on the 4-bit instance: lock, then alternate bad/good
    doReset();
    for (int k = 0; k < 8; k++) begin
      pos = 3'(k + 1);
      satStep(pat[k], 1'b0, (k == 7), pos, 1'b0, 16'd0);
    end
    pos = 3'd0;
    n_err = 16'd0;
    for (int k = 0; k < 20; k++) begin
      if (n_err != 16'd15) n_err = n_err + 16'd1;
      satStep(~pat[pos], 1'b0, 1'b1, pos + 3'd1, 1'b1, n_err);
      pos = pos + 3'd1;
      satStep(pat[pos], 1'b0, 1'b1, pos + 3'd1, 1'b0, n_err);
      pos = pos + 3'd1;
    end
    // Clear on a mismatch cycle wins, next mismatch counts from zero
    satStep(~pat[pos], 1'b1, 1'b1, pos + 3'd1, 1'b1, 16'd0);
    pos = pos + 3'd1;
    satStep(~pat[pos], 1'b0, 1'b1, pos + 3'd1, 1'b1, 16'd1);

    checkField("sb_drained", 0, 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sequence_checker.md
# sequence_checker

Receives the 8-byte pattern stream from the upstream sequence generator and aligns to it by hunting for the unique start byte. It then verifies every following byte against the expected pattern and reports lock status, per-byte mismatch pulses and a saturating error count. It sits directly downstream of the generator as the link-integrity monitor for the test pattern path.

## Interface

- `LOCK_CONFIRM`, default 8: consecutive matching bytes, counting the start byte, needed to declare lock (range 2–255).
- `LOSS_THRESH`, default 3: consecutive mismatches while locked that drop lock (range 1–15).
- `CNT_W`, default 16: width of the error counter.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_data` is a sampled stream byte this cycle.
- `in_data` input 8: stream byte.
- `clear_counts` input 1: synchronous clear of `err_count`.
- `locked` output 1: aligned and verified.
- `exp_idx` output 3: pattern index expected for the next valid byte.
- `mismatch` output 1: one-cycle pulse, locked byte differed from expectation.
- `lock_lost` output 1: one-cycle pulse on the LOCKED→HUNT transition.
- `err_count` output `CNT_W`: mismatches counted while locked; saturates at all-ones.

## Operation

- Expected pattern, index 0..7: AF, BC, E2, 78, FF, E2, 0B, 8D.
  - AF occurs only at index 0 and is the alignment byte.
  - E2 is duplicated, so it must never be used for alignment.
- `exp_idx` increments modulo 8 on every accepted byte outside HUNT; 7→0 wraps silently.
- Bytes with `in_valid`=0 are ignored entirely; state, index and counters hold.
- HUNT
  - Valid AF → VERIFY, `exp_idx`=1, match run=1.
  - Any other byte → stay in HUNT, `exp_idx`=0.
- VERIFY
  - Valid byte equal to pattern[`exp_idx`]: run+1 and index+1. When run reaches `LOCK_CONFIRM` → LOCKED, miss run=0.
  - Mismatch on an AF byte: restart VERIFY with `exp_idx`=1, run=1.
  - Mismatch on any other byte → HUNT, `exp_idx`=0.
  - No mismatch pulses and no counting in VERIFY.
- LOCKED
  - Match: index+1, miss run=0.
  - Mismatch: index+1 (the pattern position still advances), `mismatch` pulse, `err_count`+1 (saturating), miss run+1.
  - When miss run reaches `LOSS_THRESH` → HUNT, `lock_lost` pulse, `exp_idx`=0, `locked`=0.
- `clear_counts` has priority: in the same cycle as a counted mismatch, `err_count` becomes 0, not 1. The `mismatch` pulse still fires.

## Timing

- Reset values:
  - state HUNT
  - `locked`=0
  - `exp_idx`=0
  - `mismatch`=0
  - `lock_lost`=0
  - `err_count`=0
  - internal runs 0
- All outputs are registered and reflect the byte accepted on edge N from edge N onward, i.e. one cycle latency.
- `locked` rises on the edge that accepts the `LOCK_CONFIRM`-th consecutive match. `locked` falls together with the `lock_lost` pulse.
- `mismatch` and `lock_lost` are high for exactly one cycle per event. On the losing byte both pulse on the same edge.
- Reset asserted mid-stream returns all state to reset values immediately. After release, the block hunts afresh.
- Back-to-back valid bytes at one per cycle are supported indefinitely.

## Structure

- Package `seq_pkg` holds:
  - `SEQ_LEN`=8
  - `SEQ_START`=8'hAF
  - the 8-entry pattern constant array
  - the state enum {HUNT, VERIFY, LOCKED}
- The upstream generator imports the same package so the two blocks cannot diverge.
- Sub-module `sat_counter` (parameter width; inputs inc, clr with clr priority) implements `err_count`.
- Everything else stays flat in `sequence_checker`.

## Test plan

- Reset, then clean repeating stream starting AF, AF, BC, E2, … → second AF restarts VERIFY. `locked`=1 one cycle after the 8th consecutive match; `err_count`=0; `mismatch` never pulses.
- Locked; corrupt one byte (FF → 00) → single `mismatch` pulse, `err_count`=1, `locked` stays 1, `exp_idx` continues in sequence.
- Locked; three consecutive corrupted bytes → `err_count`=3. `lock_lost` and the third `mismatch` pulse together, `locked`=0, `exp_idx`=0. A later clean stream relocks.
- Stream E2, 0B, 8D, AF, BC, … from HUNT, with `in_valid` toggling every other cycle → E2 is not used to align; lock timing counts only valid bytes.
- Force `err_count` to all-ones minus 1 via repeated errors with `LOSS_THRESH`=15 → count saturates at all-ones. Asserting `clear_counts` on a mismatch cycle yields 0.
- Assert `rst_n` low while locked mid-pattern → all outputs return to reset values without waiting for a clock edge.
